// File: rtl/mosi_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mosi_frame_sequencer_pkg
// Shared constants and the sequencer state encoding for one acquisition frame
// of MOSI command slots: NUM_CONVERT CONVERT slots followed by NUM_AUX
// auxiliary slots whose commands are fetched from external command-list RAM.
// ---------------------------------------------------------------------------
package mosi_frame_sequencer_pkg;

    localparam int NUM_CONVERT   = 32;
    localparam int NUM_AUX       = 3;
    localparam int AUX_ADDR_W    = 10;
    localparam int NUM_SLOTS     = NUM_CONVERT + NUM_AUX;
    localparam int AUX_SLOT_BASE = NUM_CONVERT;
    localparam int CMD_W         = 16;
    localparam int CH_W          = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_CONV      = 3'd2,
        ST_FETCH     = 3'd3,
        ST_LATCH     = 3'd4,
        ST_AUX       = 3'd5,
        ST_FRAME_END = 3'd6
    } state_t;

endpackage

// File: rtl/mosi_frame_sequencer_aux_index_ctr.sv
// ---------------------------------------------------------------------------
// mosi_frame_sequencer_aux_index_ctr
// Read index for one auxiliary command-list bank.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   i_clr          zero the index (gated to IDLE by the parent)
//   i_advance      step the index once per completed frame
//   i_end          last index of the list
//   i_loop         index reloaded after i_end has been used
//   o_index        current read index
// ---------------------------------------------------------------------------
module mosi_frame_sequencer_aux_index_ctr
    import mosi_frame_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clr,
    input  logic                  i_advance,
    input  logic [AUX_ADDR_W-1:0] i_end,
    input  logic [AUX_ADDR_W-1:0] i_loop,
    output logic [AUX_ADDR_W-1:0] o_index
);

    logic [AUX_ADDR_W-1:0] r_index;

    // After the end entry the list restarts at loop; otherwise step by one.
    // A loop value above end simply counts on through the natural 2^W wrap.
    function automatic logic [AUX_ADDR_W-1:0] next_index(
        input logic [AUX_ADDR_W-1:0] idx,
        input logic [AUX_ADDR_W-1:0] last,
        input logic [AUX_ADDR_W-1:0] reload
    );
        if (idx == last) begin
            next_index = reload;
        end else begin
            next_index = idx + AUX_ADDR_W'(1);
        end
    endfunction

    // Index register: cleared by reset or clr, stepped once per frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_index <= {AUX_ADDR_W{1'b0}};
        end else if (i_clr) begin
            r_index <= {AUX_ADDR_W{1'b0}};
        end else if (i_advance) begin
            r_index <= next_index(r_index, i_end, i_loop);
        end else begin
            r_index <= r_index;
        end
    end

    assign o_index = r_index;

endmodule

// File: rtl/mosi_frame_sequencer.sv
// ---------------------------------------------------------------------------
// mosi_frame_sequencer
// Walks one frame of MOSI command slots (CONVERT 0..31, then aux 32..34),
// handshaking every slot with the SPI shift engine and fetching each aux
// command from its own command-list RAM bank.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   run, continuous         framing enable; continuous ignores max_frames
//   max_frames              frame budget when continuous=0
//   settle_req              captured at frame start into dsp_settle
//   aux_end, aux_loop       per-bank end / reload indices (bank0 in LSBs)
//   index_clr               zero all bank indices (IDLE only)
//   aux_mem_*               command-list RAM read port (1-cycle latency)
//   channel, dsp_settle,
//   aux_cmd                 command selector inputs
//   cmd_valid, cmd_ready    slot handshake with the SPI engine
//   busy, frame_done,
//   frame_count             status
// ---------------------------------------------------------------------------
module mosi_frame_sequencer
    import mosi_frame_sequencer_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic                          continuous,
    input  logic [31:0]                   max_frames,
    input  logic                          settle_req,
    input  logic [NUM_AUX*AUX_ADDR_W-1:0] aux_end,
    input  logic [NUM_AUX*AUX_ADDR_W-1:0] aux_loop,
    input  logic                          index_clr,
    output logic                          aux_mem_rd_en,
    output logic [1:0]                    aux_mem_sel,
    output logic [AUX_ADDR_W-1:0]         aux_mem_addr,
    input  logic [CMD_W-1:0]              aux_mem_rdata,
    output logic [CH_W-1:0]               channel,
    output logic                          dsp_settle,
    output logic [CMD_W-1:0]              aux_cmd,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic [31:0]                   frame_count
);

    localparam logic [CH_W-1:0] LAST_CONV = CH_W'(AUX_SLOT_BASE - 1);
    localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_SLOTS - 1);

    state_t                r_state;
    logic [CH_W-1:0]       r_channel;
    logic                  r_dsp_settle;
    logic [CMD_W-1:0]      r_aux_cmd;
    logic                  r_cmd_valid;
    logic                  r_rd_en;
    logic [1:0]            r_sel;
    logic [AUX_ADDR_W-1:0] r_addr;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [31:0]           r_frame_count;

    logic                  w_clr;
    logic                  w_advance;
    logic [AUX_ADDR_W-1:0] w_index [NUM_AUX];
    logic [1:0]            w_next_sel;
    logic [AUX_ADDR_W-1:0] w_next_addr;

    assign w_clr     = index_clr && (r_state == ST_IDLE);
    assign w_advance = (r_state == ST_FRAME_END);

    for (genvar b = 0; b < NUM_AUX; b++) begin : g_bank
        mosi_frame_sequencer_aux_index_ctr u_idx (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_clr     (w_clr),
            .i_advance (w_advance),
            .i_end     (aux_end[b*AUX_ADDR_W +: AUX_ADDR_W]),
            .i_loop    (aux_loop[b*AUX_ADDR_W +: AUX_ADDR_W]),
            .o_index   (w_index[b])
        );
    end

    // Bank and address for the next FETCH: bank 0 after the last CONVERT
    // slot, otherwise the bank after the one just served.
    always_comb begin
        w_next_sel  = 2'd0;
        w_next_addr = {AUX_ADDR_W{1'b0}};
        if (r_state == ST_AUX) begin
            w_next_sel = r_sel + 2'd1;
        end else begin
            w_next_sel = 2'd0;
        end
        case (w_next_sel)
            2'd0:    w_next_addr = w_index[0];
            2'd1:    w_next_addr = w_index[1];
            2'd2:    w_next_addr = w_index[2];
            default: w_next_addr = {AUX_ADDR_W{1'b0}};
        endcase
    end

    // Frame sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_channel     <= {CH_W{1'b0}};
            r_dsp_settle  <= 1'b0;
            r_aux_cmd     <= {CMD_W{1'b0}};
            r_cmd_valid   <= 1'b0;
            r_rd_en       <= 1'b0;
            r_sel         <= 2'd0;
            r_addr        <= {AUX_ADDR_W{1'b0}};
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 32'd0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_valid <= 1'b0;
                    if (run && (continuous || (max_frames != 32'd0))) begin
                        r_state       <= ST_START;
                        r_busy        <= 1'b1;
                        r_frame_count <= 32'd0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_START: begin
                    r_dsp_settle <= settle_req;
                    r_channel    <= {CH_W{1'b0}};
                    r_cmd_valid  <= 1'b1;
                    r_state      <= ST_CONV;
                end
                ST_CONV: begin
                    // cmd_valid stays high across consecutive CONVERT slots
                    if (cmd_ready) begin
                        r_channel <= r_channel + CH_W'(1);
                        if (r_channel == LAST_CONV) begin
                            r_cmd_valid <= 1'b0;
                            r_rd_en     <= 1'b1;
                            r_sel       <= w_next_sel;
                            r_addr      <= w_next_addr;
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_aux_cmd   <= aux_mem_rdata;
                    r_cmd_valid <= 1'b1;
                    r_state     <= ST_AUX;
                end
                ST_AUX: begin
                    if (cmd_ready) begin
                        r_channel   <= r_channel + CH_W'(1);
                        r_cmd_valid <= 1'b0;
                        if (r_channel == LAST_SLOT) begin
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + 32'd1;
                            r_state       <= ST_FRAME_END;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_sel   <= w_next_sel;
                            r_addr  <= w_next_addr;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FRAME_END: begin
                    // frame_count already includes the frame just finished
                    if (!run || (!continuous && (r_frame_count == max_frames))) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_START;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign aux_mem_rd_en = r_rd_en;
    assign aux_mem_sel   = r_sel;
    assign aux_mem_addr  = r_addr;
    assign channel       = r_channel;
    assign dsp_settle    = r_dsp_settle;
    assign aux_cmd       = r_aux_cmd;
    assign cmd_valid     = r_cmd_valid;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_mosi_frame_sequencer.sv
module tb_mosi_frame_sequencer;
    import mosi_frame_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, run, continuous, settle_req, index_clr, cmd_ready;
    logic [31:0] max_frames;
    logic [29:0] aux_end, aux_loop;
    logic        aux_mem_rd_en;
    logic [1:0]  aux_mem_sel;
    logic [9:0]  aux_mem_addr;
    logic [15:0] aux_mem_rdata = 16'd0;
    logic [5:0]  channel;
    logic        dsp_settle, cmd_valid, busy, frame_done;
    logic [15:0] aux_cmd;
    logic [31:0] frame_count;

    always #5 clk = ~clk;

    mosi_frame_sequencer dut (
        .clk(clk), .reset_n(reset_n), .run(run), .continuous(continuous),
        .max_frames(max_frames), .settle_req(settle_req), .aux_end(aux_end),
        .aux_loop(aux_loop), .index_clr(index_clr), .aux_mem_rd_en(aux_mem_rd_en),
        .aux_mem_sel(aux_mem_sel), .aux_mem_addr(aux_mem_addr),
        .aux_mem_rdata(aux_mem_rdata), .channel(channel), .dsp_settle(dsp_settle),
        .aux_cmd(aux_cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    typedef struct { int ch; logic settle; logic [15:0] cmd; } slot_t;
    typedef struct { int b; int a; } rd_t;
    slot_t slot_q[$];
    rd_t   rd_q[$];

    int n_asserts = 0;
    int n_fails   = 0;

    // reference state: per-bank index/end/loop and per-frame settle pattern
    int m_idx[3], m_end[3], m_loop[3];
    logic pat[16];
    int drop_frame = -1, drop_ch = 0, stall_ch = -1, stall_pct = 0, reset_frame = -1;
    int done_cnt, fd_lat;

    function automatic logic [15:0] ram_word(input int b, input int a);
        logic [1:0] bb;
        logic [9:0] aa;
        bb = b[1:0];
        aa = a[9:0];
        return 16'h8305 ^ {bb, 4'h0, aa};
    endfunction

    // command-list RAM: one-cycle read latency, logs every read
    always @(posedge clk) begin
        if (aux_mem_rd_en) begin
            aux_mem_rdata <= ram_word(int'(aux_mem_sel), int'(aux_mem_addr));
            rd_q.push_back('{int'(aux_mem_sel), int'(aux_mem_addr)});
        end
    end

    // slot log: a slot is consumed at the edge after valid&ready is seen
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready)
            slot_q.push_back('{int'(channel), dsp_settle, aux_cmd});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string t);
        check({t, "_channel"},  32'(channel), 32'd0);
        check({t, "_settle"},   32'(dsp_settle), 32'd0);
        check({t, "_aux_cmd"},  32'(aux_cmd), 32'd0);
        check({t, "_valid"},    32'(cmd_valid), 32'd0);
        check({t, "_rd_en"},    32'(aux_mem_rd_en), 32'd0);
        check({t, "_sel"},      32'(aux_mem_sel), 32'd0);
        check({t, "_addr"},     32'(aux_mem_addr), 32'd0);
        check({t, "_busy"},     32'(busy), 32'd0);
        check({t, "_fdone"},    32'(frame_done), 32'd0);
        check({t, "_fcount"},   frame_count, 32'd0);
    endtask

    task automatic apply_cfg();
        aux_end  = {m_end[2][9:0],  m_end[1][9:0],  m_end[0][9:0]};
        aux_loop = {m_loop[2][9:0], m_loop[1][9:0], m_loop[0][9:0]};
    endtask

    task automatic pulse_clr();
        index_clr = 1'b1;
        @(posedge clk); #1;
        index_clr = 1'b0;
        for (int b = 0; b < 3; b++) m_idx[b] = 0;
    endtask

    // Drive one run from IDLE back to IDLE, with randomized ready stalls and
    // settle_req randomized everywhere except the START cycle.
    task automatic drive(input int budget);
        int cyc = 0, stall_cnt = 0, start_cyc = 0;
        bit prev_busy = 0, prev_fd = 0, stalled = 0, post = 0, finished = 0;
        done_cnt = 0;
        fd_lat = -1;
        run = 1'b1;
        cmd_ready = 1'b1;
        while (!finished && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (reset_frame >= 0 && done_cnt == reset_frame && aux_mem_rd_en) begin
                reset_n = 1'b0;
                run = 1'b0;
                @(posedge clk); #1;
                check_idle("rst_fetch");
                @(posedge clk); #1;
                check("rst_hold_valid", 32'(cmd_valid), 32'd0);
                reset_n = 1'b1;
                finished = 1;
            end else begin
                if (busy && !prev_busy) start_cyc = cyc;
                if (frame_done) begin
                    if (done_cnt == 0) fd_lat = cyc - start_cyc;
                    done_cnt++;
                end
                if (busy && (!prev_busy || prev_fd)) settle_req = pat[done_cnt];
                else settle_req = 1'($urandom_range(1));
                if (drop_frame >= 0 && done_cnt == drop_frame && cmd_valid && int'(channel) == drop_ch)
                    run = 1'b0;
                if (post) begin
                    check("stall_next_ch", 32'(channel), 32'(stall_ch + 1));
                    check("stall_next_valid", 32'(cmd_valid), 32'd1);
                    post = 0;
                end
                if (stall_ch >= 0 && !stalled && cmd_valid && int'(channel) == stall_ch) begin
                    stall_cnt++;
                    cmd_ready = (stall_cnt == 6);
                    if (stall_cnt == 6) begin
                        stalled = 1;
                        post = 1;
                    end
                end else begin
                    cmd_ready = ($urandom_range(99) >= stall_pct);
                end
                if (!busy && prev_busy) begin
                    finished = 1;
                    run = 1'b0;
                end
                prev_busy = busy;
                prev_fd = frame_done;
            end
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        run = 1'b0;
        cmd_ready = 1'b0;
        if (stall_ch >= 0) check("stall_cycles", stall_cnt, 32'd6);
    endtask

    // Compare logged slots and RAM reads against the frame-level model.
    task automatic verify(input int n);
        slot_t s;
        rd_t   r;
        check("frames_done", done_cnt, n);
        check("frame_count", frame_count, n);
        check("busy_end", 32'(busy), 32'd0);
        check("slot_total", slot_q.size(), 35 * n);
        check("read_total", rd_q.size(), 3 * n);
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < 35; k++) begin
                if (slot_q.size() > 0) begin
                    s = slot_q.pop_front();
                    check($sformatf("ch f%0d s%0d", f, k), s.ch, k);
                    check($sformatf("settle f%0d s%0d", f, k), 32'(s.settle), 32'(pat[f]));
                    if (k >= 32)
                        check($sformatf("aux_cmd f%0d s%0d", f, k), 32'(s.cmd),
                              32'(ram_word(k - 32, m_idx[k - 32])));
                end
            end
            for (int b = 0; b < 3; b++) begin
                if (rd_q.size() > 0) begin
                    r = rd_q.pop_front();
                    check($sformatf("rd_bank f%0d b%0d", f, b), r.b, b);
                    check($sformatf("rd_addr f%0d b%0d", f, b), r.a, m_idx[b]);
                end
            end
            for (int b = 0; b < 3; b++)
                m_idx[b] = (m_idx[b] == m_end[b]) ? m_loop[b] : (m_idx[b] + 1) % 1024;
        end
        slot_q.delete();
        rd_q.delete();
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; continuous = 1'b0; max_frames = 32'd0;
        settle_req = 1'b0; index_clr = 1'b0; cmd_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_idx[b]  = 0;
            m_end[b]  = $urandom_range(1023);
            m_loop[b] = $urandom_range(1023);
        end
        for (int i = 0; i < 16; i++) pat[i] = 1'($urandom_range(1));
        apply_cfg();
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single frame, ready tied high: minimum frame time
        max_frames = 32'd1;
        drive(200);
        verify(1);
        check("frame_done_latency", fd_lat, 42);

        // bank0 end=2 loop=1; bank2 loops past end through the 2^W wrap
        pulse_clr();
        m_end[0] = 2;  m_loop[0] = 1;
        m_end[2] = 1;  m_loop[2] = 1020;
        apply_cfg();
        max_frames = 32'd8;
        stall_pct = 20;
        drive(2000);
        verify(8);

        // long stall on slot 7
        stall_ch = 7; stall_pct = 30; max_frames = 32'd1;
        drive(500);
        verify(1);
        stall_ch = -1;

        // continuous ignores max_frames; run dropped in slot 10 of frame 3
        continuous = 1'b1; max_frames = 32'd1;
        drop_frame = 2; drop_ch = 10; stall_pct = 10;
        drive(2000);
        verify(3);
        drop_frame = -1; continuous = 1'b0;

        // settle only in frame 2, then index_clr restarts all banks at 0
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0;
        max_frames = 32'd3; stall_pct = 0;
        drive(1000);
        verify(3);
        pulse_clr();
        max_frames = 32'd1;
        drive(500);
        verify(1);

        // reset during FETCH of the second frame, then a clean restart
        continuous = 1'b1; reset_frame = 1;
        drive(2000);
        reset_frame = -1; continuous = 1'b0;
        slot_q.delete();
        rd_q.delete();
        for (int b = 0; b < 3; b++) m_idx[b] = 0;
        @(posedge clk); #1;
        max_frames = 32'd1;
        drive(500);
        verify(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/mosi_frame_sequencer.md
Name: mosi_frame_sequencer

Overview:
- Sequences one acquisition frame of 35 MOSI command slots: 32 CONVERT slots (channel 0..31), then 3 auxiliary slots (32..34).
- Drives the channel index, DSP_settle and aux_cmd inputs of the command selector.
- Handshakes each slot with the SPI shift engine.
- Fetches auxiliary commands from three external command-list RAM banks, each with its own end/loop index pointer.

Parameters:
NUM_CONVERT, 32, number of CONVERT slots per frame (channels 0..NUM_CONVERT-1)
NUM_AUX, 3, number of auxiliary slots/banks following the CONVERT slots
AUX_ADDR_W, 10, address width of each aux command-list bank

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
run  in  1  level; start/continue framing
continuous  in  1  1 = ignore max_frames
max_frames  in  32  frames to run when continuous=0
settle_req  in  1  sampled at frame start; drives DSP_settle for whole frame
aux_end  in  NUM_AUX*AUX_ADDR_W  per-bank last index (bank0 in LSBs)
aux_loop  in  NUM_AUX*AUX_ADDR_W  per-bank reload index after end
index_clr  in  1  pulse; zero all aux indices (honoured in IDLE only)
aux_mem_rd_en  out  1  RAM read strobe
aux_mem_sel  out  2  bank select
aux_mem_addr  out  AUX_ADDR_W  RAM address
aux_mem_rdata  in  16  RAM data, valid cycle after rd_en
channel  out  6  slot index to command selector
dsp_settle  out  1  to command selector
aux_cmd  out  16  to command selector
cmd_valid  out  1  slot command ready for SPI engine
cmd_ready  in  1  SPI engine has shifted the slot; completes handshake
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse after slot 34 completes
frame_count  out  32  frames completed since leaving IDLE

Behaviour:
- Reset (reset_n=0 at clk edge), all outputs:
  - state=IDLE; channel=0, dsp_settle=0, aux_cmd=0, cmd_valid=0, aux_mem_rd_en=0, aux_mem_sel=0, aux_mem_addr=0, busy=0, frame_done=0, frame_count=0.
  - All aux indices = 0.
  - Reset mid-frame aborts immediately; no further cmd_valid.
- States: IDLE, START, CONV, FETCH, LATCH, AUX, FRAME_END.
- IDLE:
  - index_clr=1 zeroes indices.
  - run=1 and (continuous=1 or max_frames!=0) -> START; otherwise stay.
- START (1 cycle):
  - dsp_settle<=settle_req; channel<=0 -> CONV.
  - frame_count cleared only on IDLE->START, not between frames.
- CONV:
  - cmd_valid=1, held with channel stable until cmd_ready=1.
  - On the handshake cycle, channel<=channel+1. If channel was NUM_CONVERT-1 -> FETCH, else stay CONV.
  - cmd_valid is not dropped between consecutive CONV slots.
- FETCH:
  - cmd_valid=0; aux_mem_rd_en=1, aux_mem_sel=channel-NUM_CONVERT, aux_mem_addr=index[sel] -> LATCH.
- LATCH:
  - aux_cmd<=aux_mem_rdata -> AUX.
  - Read latency is fixed at 1 cycle; no wait states.
- AUX:
  - cmd_valid=1 until cmd_ready.
  - On handshake, channel<=channel+1. Last aux slot -> FRAME_END, else FETCH.
- FRAME_END (1 cycle):
  - frame_done=1; frame_count+=1.
  - Each bank index: index==aux_end ? aux_loop : index+1, wrapping 2^AUX_ADDR_W-1 -> 0. Indices advance only here, so all 3 aux slots of a frame use the same index.
  - Next state: if run=0, or continuous=0 and frame_count+1==max_frames -> IDLE. Else START, sampling settle_req afresh.
- run=0 mid-frame: the current frame completes fully (all 35 slots, index advance), then IDLE.
- cmd_ready while cmd_valid=0 is ignored.
- aux_end/aux_loop/max_frames/continuous are sampled live; they must be changed only in IDLE, otherwise behaviour is undefined.
- aux_loop>aux_end: the index runs past end, wraps at 2^W, and then reaches end normally.
- Minimum frame time with cmd_ready tied high: 1 + 32 + 3*3 + 1 = 43 cycles.

Decomposition:
- Shared package holds:
  - state enum;
  - constants NUM_SLOTS=NUM_CONVERT+NUM_AUX;
  - AUX_SLOT_BASE=NUM_CONVERT;
  - CMD_W=16.
- One sub-module: aux_index_ctr, one per bank. It holds the index register and the end/loop/wrap logic, with inputs advance and clr.

Test Plan:
- Reset then run=1, continuous=0, max_frames=1, cmd_ready=1 -> channel steps 0..34 once; frame_done pulses at cycle 42 after START; frame_count=1; back in IDLE with busy=0.
- aux_end[0]=2, aux_loop[0]=1, run 6 frames -> bank-0 addresses per frame read 0,1,2,1,2,1; RAM word 16'h8305 is returned on aux_cmd at slot 32.
- cmd_ready held low 5 cycles on slot 7 -> channel stays 7 and cmd_valid stays high for 6 cycles; slot 8 follows the handshake.
- continuous=1, run dropped during slot 10 of frame 3 -> frame 3 completes to slot 34; frame_count=3; IDLE.
- settle_req=1 only in START of frame 2 -> dsp_settle=1 for all of frame 2 only; index_clr in IDLE -> next frame reads address 0 in all banks.
- reset_n=0 during FETCH -> next cycle all outputs at reset values; indices 0; a subsequent run restarts at channel 0.
